// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and idle level for the debouncer
package debounce_pkg;
  typedef enum logic {STABLE = 1'b0, PEND = 1'b1} state_t;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/debounce_timer.sv
// debounce_timer: run-length counter with sync clear/enable and terminal flag
module debounce_timer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);
  localparam int W = $clog2(STABLE_CYCLES + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign term = count == W'(STABLE_CYCLES - 1);
endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: debounces a synchronized level and reports edges, glitches and an edge count
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync_in,
  input  logic                   clear,
  output logic                   debounced_out,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic                   glitch_flag,
  output logic [COUNT_WIDTH-1:0] edge_count
);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  state_t state, state_nxt;
  logic mismatch, accept, abandon, tclr, ten, term;
  logic out_nxt, rise_nxt, fall_nxt, glitch_nxt;
  logic [COUNT_WIDTH-1:0] cnt_nxt;
  assign mismatch = sync_in != debounced_out;
  debounce_timer #(.STABLE_CYCLES(STABLE_CYCLES)) timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tclr),
    .en   (ten),
    .term (term)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= STABLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == STABLE ? ((mismatch && STABLE_CYCLES > 1) ? PEND : STABLE)
                                : ((!mismatch || term) ? STABLE : PEND);
  // A one-cycle filter accepts straight from STABLE; otherwise the timer decides.
  always_comb begin
    accept     = mismatch && (state == STABLE ? STABLE_CYCLES == 1 : term);
    abandon    = state == PEND && !mismatch;
    tclr       = !mismatch || accept;
    ten        = mismatch && !accept;
    out_nxt    = debounced_out ^ accept;
    rise_nxt   = accept && !debounced_out;
    fall_nxt   = accept && debounced_out;
    glitch_nxt = abandon;
    cnt_nxt    = clear ? '0 : (accept && edge_count != CNT_MAX) ? edge_count + 1'b1 : edge_count;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      debounced_out <= IDLE_LEVEL;
      rise_pulse    <= 1'b0;
      fall_pulse    <= 1'b0;
      glitch_flag   <= 1'b0;
      edge_count    <= '0;
    end else begin
      debounced_out <= out_nxt;
      rise_pulse    <= rise_nxt;
      fall_pulse    <= fall_nxt;
      glitch_flag   <= glitch_nxt;
      edge_count    <= cnt_nxt;
    end
endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: table vectors, directed corner sequences and random stimulus vs a run-length model
module tb_debounce_edge;
  logic clk = 1'b0, rst = 1'b0, sync_in = 1'b1, clear = 1'b0;
  logic debounced_out, rise_pulse, fall_pulse, glitch_flag;
  logic [3:0] edge_count;
  int n_cmp = 0, n_bad = 0;
  logic m_lvl, m_rise, m_fall, m_glitch;
  logic [3:0] m_cnt;
  int m_run;
  typedef struct {
    logic       s;
    logic       c;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[22];
  wire [7:0] dv = {debounced_out, rise_pulse, fall_pulse, glitch_flag, edge_count};

  debounce_edge #(.STABLE_CYCLES(4), .COUNT_WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .sync_in       (sync_in),
    .clear         (clear),
    .debounced_out (debounced_out),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .glitch_flag   (glitch_flag),
    .edge_count    (edge_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_lvl = 1'b1; m_run = 0; m_rise = 0; m_fall = 0; m_glitch = 0; m_cnt = 0;
  endtask

  // Level flips once 4 consecutive samples disagree with it; a shorter disagreeing run is a glitch.
  task automatic model(input logic s, input logic c);
    m_rise = 0; m_fall = 0; m_glitch = 0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == 4) begin
        m_lvl = s; m_run = 0; m_rise = s; m_fall = !s;
        if (m_cnt != 4'd15) m_cnt++;
      end
    end else begin
      m_glitch = m_run > 0;
      m_run = 0;
    end
    if (c) m_cnt = 0;
  endtask

  function automatic logic [7:0] mvec();
    return {m_lvl, m_rise, m_fall, m_glitch, m_cnt};
  endfunction

  task automatic step(input logic s, input logic c);
    sync_in = s; clear = c;
    @(posedge clk);
    model(s, c);
    @(negedge clk);
  endtask

  function automatic vec_t v(logic s, logic c, logic o, logic r, logic f, logic g, logic [3:0] n);
    return '{s, c, {o, r, f, g, n}};
  endfunction

  initial begin
    int nr, nf, total, hold;
    logic rs;
    vt[0]  = v(0,0, 1,0,0,0, 0);  vt[1]  = v(0,0, 1,0,0,0, 0);
    vt[2]  = v(0,0, 1,0,0,0, 0);  vt[3]  = v(0,0, 0,0,1,0, 1);
    vt[4]  = v(0,0, 0,0,0,0, 1);  vt[5]  = v(1,0, 0,0,0,0, 1);
    vt[6]  = v(1,0, 0,0,0,0, 1);  vt[7]  = v(1,0, 0,0,0,0, 1);
    vt[8]  = v(0,0, 0,0,0,1, 1);  vt[9]  = v(0,0, 0,0,0,0, 1);
    vt[10] = v(1,0, 0,0,0,0, 1);  vt[11] = v(1,0, 0,0,0,0, 1);
    vt[12] = v(1,0, 0,0,0,0, 1);  vt[13] = v(1,0, 1,1,0,0, 2);
    vt[14] = v(0,0, 1,0,0,0, 2);  vt[15] = v(0,0, 1,0,0,0, 2);
    vt[16] = v(0,0, 1,0,0,0, 2);  vt[17] = v(1,0, 1,0,0,1, 2);
    vt[18] = v(1,1, 1,0,0,0, 0);  vt[19] = v(1,0, 1,0,0,0, 0);
    vt[20] = v(0,0, 1,0,0,0, 0);  vt[21] = v(1,0, 1,0,0,1, 0);

    #2 rst = 1'b1;
    #1 chk("reset", dv, 8'b1000_0000);
    @(negedge clk);
    chk("reset_hold", dv, 8'b1000_0000);
    rst = 1'b0;
    mreset();

    for (int i = 0; i < 22; i++) begin
      step(vt[i].s, vt[i].c);
      chk($sformatf("vec%0d", i), dv, vt[i].exp);
    end

    total = 0;
    for (int t = 0; t < 20; t++) begin
      nr = 0; nf = 0;
      for (int k = 0; k < 6; k++) begin
        step(t[0], 1'b0);
        chk("sat_model", dv, mvec());
        nr += int'(rise_pulse);
        nf += int'(fall_pulse);
      end
      chk("sat_pulse", 8'(nr * 4 + nf), t[0] ? 8'd4 : 8'd1);
      total += nr + nf;
    end
    chk("sat_total", 8'(total), 8'd20);
    chk("sat_cnt", 8'(edge_count), 8'd15);

    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0);
      if (k == 3) chk("clean_fall_sat", dv, 8'b0010_1111);
      else chk("clean_fall", dv, mvec());
    end

    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", dv, 8'b1000_0000);
    @(negedge clk);
    chk("async_rst_hold1", dv, 8'b1000_0000);
    @(negedge clk);
    chk("async_rst_hold2", dv, 8'b1000_0000);
    rst = 1'b0;
    mreset();

    step(1'b0, 1'b0); chk("pend_a", dv, mvec());
    step(1'b0, 1'b0); chk("pend_b", dv, mvec());
    rst = 1'b1;
    #1 chk("pend_rst", dv, 8'b1000_0000);
    @(negedge clk);
    rst = 1'b0;
    mreset();
    nf = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      chk("pend_model", dv, mvec());
      chk("pend_out", 8'({debounced_out, fall_pulse}), (i < 3) ? 8'd2 : (i == 3) ? 8'd1 : 8'd0);
      nf += int'(fall_pulse);
    end
    chk("pend_falls", 8'(nf), 8'd1);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("clr_model", dv, mvec());
    chk("clr_cnt", 8'(edge_count), 8'd0);
    chk("clr_rise_out", 8'({rise_pulse, debounced_out}), 8'd3);

    hold = 0;
    rs = 1'b1;
    repeat (1500) begin
      if (hold == 0) begin
        rs = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 7));
      end
      hold--;
      step(rs, $urandom_range(0, 11) == 0);
      chk("rand", dv, mvec());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
